// File: rtl/tinyalu_pkg.sv
// +----------------------------------------------------------------------------+
// | tinyalu_pkg: shared types and register map for the TinyALU bus target.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package tinyalu_pkg;

    typedef enum logic [0:0] {
        bus_rd = 1'b0,
        bus_wr = 1'b1
    } bus_op_t;

    localparam logic [15:0] ADDR_A      = 16'h0000;
    localparam logic [15:0] ADDR_B      = 16'h0001;
    localparam logic [15:0] ADDR_OP     = 16'h0002;
    localparam logic [15:0] ADDR_CTRL   = 16'h0003;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_RESULT = 16'h0005;
    localparam logic [15:0] ADDR_ID     = 16'h0006;

    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_ERR  = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/simple_bus_alu_target_if.sv
// +----------------------------------------------------------------------------+
// | simple_bus_alu_target_if: single-cycle simple bus, initiator/target views. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface simple_bus_alu_target_if;

    logic                 bus_valid;
    tinyalu_pkg::bus_op_t bus_op;
    logic [15:0]          bus_addr;
    logic [15:0]          bus_wr_data;
    logic [15:0]          bus_rd_data;

    modport master (
        output bus_valid,
        output bus_op,
        output bus_addr,
        output bus_wr_data,
        input  bus_rd_data
    );

    modport slave (
        input  bus_valid,
        input  bus_op,
        input  bus_addr,
        input  bus_wr_data,
        output bus_rd_data
    );

endinterface

`default_nettype wire

// File: rtl/simple_bus_alu_target.sv
// +----------------------------------------------------------------------------+
// | simple_bus_alu_target: register-mapped command port for the TinyALU core.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module simple_bus_alu_target
    import tinyalu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [15:0] ID_VALUE       = 16'hA1C0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    simple_bus_alu_target_if.slave bus,
    output logic [7:0]             alu_A,
    output logic [7:0]             alu_B,
    output logic [2:0]             alu_op,
    output logic                   alu_start,
    input  wire logic              alu_done,
    input  wire logic [15:0]       alu_result
);

    localparam int                CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    alu_state_t        state;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [7:0]        reg_a;
    logic [7:0]        reg_b;
    logic [2:0]        reg_op;
    logic [15:0]       reg_result;
    logic              done_flag;
    logic              err_flag;

    logic              busy;
    logic              wr;
    logic              rd;
    logic              ctrl_wr;
    logic              start_req;
    logic              clr_done_req;
    logic              clr_err_req;
    logic              opnd_wr;
    logic              mapped_wr;
    logic              timeout_hit;
    logic              err_set;
    logic              done_set;
    logic              done_clr;
    logic [15:0]       rd_mux;
    logic              unused_wr_hi;

    assign busy         = (state == RUN);
    assign wr           = bus.bus_valid && (bus.bus_op == bus_wr);
    assign rd           = bus.bus_valid && (bus.bus_op == bus_rd);
    assign ctrl_wr      = wr && (bus.bus_addr == ADDR_CTRL);
    assign start_req    = ctrl_wr && bus.bus_wr_data[CTRL_START];
    assign clr_done_req = ctrl_wr && bus.bus_wr_data[CTRL_CLR_DONE];
    assign clr_err_req  = ctrl_wr && bus.bus_wr_data[CTRL_CLR_ERR];
    assign opnd_wr      = wr && ((bus.bus_addr == ADDR_A) || (bus.bus_addr == ADDR_B) ||
                                 (bus.bus_addr == ADDR_OP));
    assign mapped_wr    = opnd_wr || ctrl_wr;
    assign timeout_hit  = busy && !alu_done && (tmo_cnt == CNT_LAST);
    assign unused_wr_hi = &{1'b0, bus.bus_wr_data[15:8]};

    // Every error source is OR-ed here so a same-edge CLR_ERR cannot mask it.
    assign err_set = (busy && (opnd_wr || start_req))
                  || (wr && !mapped_wr)
                  || (rd && (bus.bus_addr > ADDR_ID))
                  || timeout_hit;

    assign done_set = (!busy && start_req && (reg_op == 3'b000)) || (busy && alu_done);
    assign done_clr = (!busy && start_req && (reg_op != 3'b000)) || clr_done_req;

    assign alu_A  = reg_a;
    assign alu_B  = reg_b;
    assign alu_op = reg_op;

    always_comb begin
        rd_mux = 16'h0000;
        case (bus.bus_addr)
            ADDR_A:      rd_mux = {8'h00, reg_a};
            ADDR_B:      rd_mux = {8'h00, reg_b};
            ADDR_OP:     rd_mux = {13'h0000, reg_op};
            ADDR_STATUS: begin
                rd_mux[STAT_BUSY] = busy;
                rd_mux[STAT_DONE] = done_flag;
                rd_mux[STAT_ERR]  = err_flag;
            end
            ADDR_RESULT: rd_mux = reg_result;
            ADDR_ID:     rd_mux = ID_VALUE;
            default:     rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            tmo_cnt         <= '0;
            reg_a           <= 8'h00;
            reg_b           <= 8'h00;
            reg_op          <= 3'b000;
            reg_result      <= 16'h0000;
            done_flag       <= 1'b0;
            err_flag        <= 1'b0;
            alu_start       <= 1'b0;
            bus.bus_rd_data <= 16'h0000;
        end else begin
            if (wr && !busy) begin
                case (bus.bus_addr)
                    ADDR_A:  reg_a  <= bus.bus_wr_data[7:0];
                    ADDR_B:  reg_b  <= bus.bus_wr_data[7:0];
                    ADDR_OP: reg_op <= bus.bus_wr_data[2:0];
                    default: ;
                endcase
            end

            if (rd) begin
                bus.bus_rd_data <= rd_mux;
            end

            if (err_set) begin
                err_flag <= 1'b1;
            end else if (clr_err_req) begin
                err_flag <= 1'b0;
            end

            if (done_set) begin
                done_flag <= 1'b1;
            end else if (done_clr) begin
                done_flag <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_req && (reg_op != 3'b000)) begin
                        state     <= RUN;
                        tmo_cnt   <= '0;
                        alu_start <= 1'b1;
                    end
                end
                RUN: begin
                    if (alu_done) begin
                        reg_result <= alu_result;
                        alu_start  <= 1'b0;
                        state      <= IDLE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        alu_start <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    alu_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_bus_alu_target.sv
// +----------------------------------------------------------------------------+
// | tb_simple_bus_alu_target: directed register-sequence bench for the target. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_simple_bus_alu_target;
    import tinyalu_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  alu_A;
    logic [7:0]  alu_B;
    logic [2:0]  alu_op;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_result;

    int          vectors;
    int          miscompares;
    int          latency;
    bit          tie_low;
    int          start_hi;
    logic [15:0] rdv;

    simple_bus_alu_target_if bus_if ();

    simple_bus_alu_target #(
        .TIMEOUT_CYCLES (16),
        .ID_VALUE       (16'hA1C0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus_if.bus_valid   = 1'b1;
        bus_if.bus_op      = bus_wr;
        bus_if.bus_addr    = addr;
        bus_if.bus_wr_data = data;
        @(negedge clk);
        bus_if.bus_valid   = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge clk);
        bus_if.bus_valid = 1'b1;
        bus_if.bus_op    = bus_rd;
        bus_if.bus_addr  = addr;
        @(negedge clk);
        bus_if.bus_valid = 1'b0;
        data = bus_if.bus_rd_data;
    endtask

    function automatic logic [15:0] alu_model(input logic [2:0] op, input logic [7:0] a,
                                              input logic [7:0] b);
        case (op)
            3'b001:  return {8'h00, a} + {8'h00, b};
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // TinyALU stand-in: raises alu_done for one cycle after `latency` cycles of alu_start.
    initial begin
        int waited;
        waited     = 0;
        alu_done   = 1'b0;
        alu_result = 16'h0000;
        forever begin
            @(negedge clk);
            if (alu_start) start_hi++;
            if (alu_start && !tie_low && !alu_done) begin
                waited++;
                if (waited >= latency) begin
                    alu_done   = 1'b1;
                    alu_result = alu_model(alu_op, alu_A, alu_B);
                    waited     = 0;
                end
            end else begin
                alu_done = 1'b0;
                waited   = 0;
            end
        end
    end

    initial begin
        vectors            = 0;
        miscompares        = 0;
        latency            = 1;
        tie_low            = 1'b0;
        start_hi           = 0;
        rst                = 1'b1;
        bus_if.bus_valid   = 1'b0;
        bus_if.bus_op      = bus_rd;
        bus_if.bus_addr    = 16'h0000;
        bus_if.bus_wr_data = 16'h0000;

        // Reset values before any clock edge
        #1;
        check_vec("rst_alu_ab",    {alu_A, alu_B}, 16'h0000);
        check_vec("rst_alu_op",    {13'h0, alu_op}, 16'h0000);
        check_vec("rst_alu_start", {15'h0, alu_start}, 16'h0000);
        check_vec("rst_rd_data",   bus_if.bus_rd_data, 16'h0000);
        @(negedge clk);
        #2 rst = 1'b0;
        bus_read(ADDR_ID, rdv);     check_vec("id", rdv, 16'hA1C0);
        bus_read(ADDR_STATUS, rdv); check_vec("rst_status", rdv, 16'h0000);

        // ADD, done after 2 cycles
        latency = 2;
        bus_write(ADDR_A, 16'h0012);
        bus_write(ADDR_B, 16'h0034);
        bus_write(ADDR_OP, 16'h0001);
        check_vec("add_operands", {alu_A, alu_B}, 16'h1234);
        check_vec("add_opcode", {13'h0, alu_op}, 16'h0001);
        start_hi = 0;
        bus_write(ADDR_CTRL, 16'h0001);
        check_vec("add_start_hi", {15'h0, alu_start}, 16'h0001);
        repeat (4) @(negedge clk);
        check_vec("add_start_cycles", 16'(start_hi), 16'd2);
        check_vec("add_start_lo", {15'h0, alu_start}, 16'h0000);
        bus_read(ADDR_RESULT, rdv); check_vec("add_result", rdv, 16'h0046);
        bus_read(ADDR_STATUS, rdv); check_vec("add_status", rdv, 16'h0002);

        // MUL, done after 3 cycles, with a poll while running
        latency = 3;
        bus_write(ADDR_A, 16'h00FF);
        bus_write(ADDR_B, 16'h00FF);
        bus_write(ADDR_OP, 16'h0004);
        start_hi = 0;
        bus_write(ADDR_CTRL, 16'h0001);
        bus_read(ADDR_STATUS, rdv); check_vec("mul_status_busy", rdv, 16'h0001);
        repeat (4) @(negedge clk);
        check_vec("mul_start_cycles", 16'(start_hi), 16'd3);
        bus_read(ADDR_RESULT, rdv); check_vec("mul_result", rdv, 16'hFE01);
        bus_read(ADDR_STATUS, rdv); check_vec("mul_status", rdv, 16'h0002);

        // Timeout with alu_done held low
        tie_low = 1'b1;
        bus_write(ADDR_OP, 16'h0001);
        start_hi = 0;
        bus_write(ADDR_CTRL, 16'h0001);
        check_vec("tmo_start_hi", {15'h0, alu_start}, 16'h0001);
        repeat (15) @(negedge clk);
        check_vec("tmo_last_cycle", {15'h0, alu_start}, 16'h0001);
        @(negedge clk);
        check_vec("tmo_start_lo", {15'h0, alu_start}, 16'h0000);
        check_vec("tmo_start_cycles", 16'(start_hi), 16'd16);
        bus_read(ADDR_STATUS, rdv); check_vec("tmo_status", rdv, 16'h0004);
        bus_read(ADDR_RESULT, rdv); check_vec("tmo_result_kept", rdv, 16'hFE01);
        bus_write(ADDR_CTRL, 16'h0004);
        bus_read(ADDR_STATUS, rdv); check_vec("tmo_clr_err", rdv, 16'h0000);

        // Busy protection and unmapped read
        tie_low = 1'b0;
        latency = 10;
        bus_write(ADDR_CTRL, 16'h0001);
        bus_write(ADDR_A, 16'h0055);
        bus_read(ADDR_A, rdv);      check_vec("busy_a_kept", rdv, 16'h00FF);
        repeat (12) @(negedge clk);
        check_vec("busy_alu_a", {8'h00, alu_A}, 16'h00FF);
        bus_read(ADDR_STATUS, rdv); check_vec("busy_status", rdv, 16'h0006);
        bus_read(ADDR_RESULT, rdv); check_vec("busy_result", rdv, 16'h01FE);
        bus_write(ADDR_CTRL, 16'h0004);
        bus_read(ADDR_STATUS, rdv); check_vec("busy_clr_err", rdv, 16'h0002);
        bus_read(16'h0009, rdv);    check_vec("unmapped_read", rdv, 16'h0000);
        bus_read(ADDR_STATUS, rdv); check_vec("unmapped_err", rdv, 16'h0006);

        // no_op command
        bus_write(ADDR_CTRL, 16'h0006);
        bus_read(ADDR_STATUS, rdv); check_vec("clr_both", rdv, 16'h0000);
        bus_write(ADDR_OP, 16'h0000);
        start_hi = 0;
        bus_write(ADDR_CTRL, 16'h0001);
        repeat (3) @(negedge clk);
        check_vec("noop_no_start", 16'(start_hi), 16'd0);
        bus_read(ADDR_STATUS, rdv); check_vec("noop_status", rdv, 16'h0002);
        bus_read(ADDR_RESULT, rdv); check_vec("noop_result", rdv, 16'h01FE);

        // Reset asserted mid-cycle while running
        tie_low = 1'b1;
        bus_write(ADDR_OP, 16'h0001);
        bus_write(ADDR_CTRL, 16'h0001);
        check_vec("rrun_start_hi", {15'h0, alu_start}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check_vec("rrun_start_async", {15'h0, alu_start}, 16'h0000);
        check_vec("rrun_alu_ab", {alu_A, alu_B}, 16'h0000);
        @(negedge clk);
        rst     = 1'b0;
        tie_low = 1'b0;
        bus_read(ADDR_STATUS, rdv); check_vec("rrun_status", rdv, 16'h0000);
        bus_read(ADDR_RESULT, rdv); check_vec("rrun_result", rdv, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/simple_bus_alu_target.md
# simple_bus_alu_target

Bus responder (target) for the simple bus: decodes single-cycle read/write transfers from the simple bus initiator into a small register map that drives the TinyALU command port. Software-style sequences write operands A/B and an opcode, write START, poll STATUS, then read RESULT. Sits between the simple bus and the TinyALU core inside the test harness.

## Interface
- TIMEOUT_CYCLES, 16, cycles in RUN without alu_done before the command is aborted (≥2)
- ID_VALUE, 16'hA1C0, constant returned by the ID register
- clk  input  1  single clock; everything samples on posedge
- rst  input  1  asynchronous, active-high reset
- bus_valid  input  1  transfer request, one cycle per transfer
- bus_op  input  1  1 = write, 0 = read
- bus_addr  input  16  word address
- bus_wr_data  input  16  write data
- bus_rd_data  output  16  registered read data
- alu_A  output  8  operand A
- alu_B  output  8  operand B
- alu_op  output  3  TinyALU opcode (000 no_op)
- alu_start  output  1  held high until alu_done sampled
- alu_done  input  1  TinyALU completion
- alu_result  input  16  TinyALU result, valid with alu_done

## Operation
- Register map (other bits read 0, ignore writes):
  - 0x0000 A [7:0] RW
  - 0x0001 B [7:0] RW
  - 0x0002 OP [2:0] RW
  - 0x0003 CTRL WO, reads 0. bit0 START, bit1 CLR_DONE, bit2 CLR_ERR. All self-clearing.
  - 0x0004 STATUS RO. bit0 busy, bit1 done (sticky), bit2 err (sticky).
  - 0x0005 RESULT [15:0] RO
  - 0x0006 ID RO = ID_VALUE
- Write of A/B/OP/START while busy: ignored, err set.
- Write to unmapped or RO address: ignored, err set.
- Read of unmapped address: returns 16'h0000, err set.
- alu_A/alu_B/alu_op are driven continuously from the A/B/OP registers.
- FSM has two states, IDLE and RUN.
  - IDLE, START with OP≠000: go to RUN, clear done, load the timeout counter with 0, assert alu_start.
  - IDLE, START with OP=000: stay in IDLE, set done, RESULT unchanged.
  - RUN, alu_done=1: capture alu_result into RESULT, set done, deassert alu_start, go to IDLE.
  - RUN, counter reaches TIMEOUT_CYCLES-1 without alu_done: set err, deassert alu_start, go to IDLE, RESULT unchanged.
- busy = (state==RUN).
- Same-edge CTRL writes: CLR_DONE with START is resolved as START; CLR_ERR concurrent with a new error source leaves err set (set wins).
- Reset values: all registers 0, state IDLE, alu_start 0, bus_rd_data 16'h0000, alu_A/B/op 0.

## Timing
- Bus transfers are sampled on the posedge where bus_valid=1. There are no wait states and no back-pressure.
- Write commits on that edge. START seen at edge N gives alu_start=1 after edge N.
- Read: bus_rd_data is registered on the same edge and is stable through the following cycle, so the initiator samples it at edge N+1. It holds its value until the next read. Writes do not change bus_rd_data.
- A read coinciding with an internal update returns the pre-update value (e.g. STATUS read on the alu_done edge shows busy=1, done=0).
- Back-to-back transfers on consecutive cycles are supported.
- alu_done is ignored in IDLE.
- Asserting rst mid-RUN drops alu_start asynchronously and clears all state.

## Structure
- Put these in tinyalu_pkg, reusing its existing bus_op_t (bus_rd/bus_wr) for decode:
  - register address localparams
  - CTRL/STATUS bit-index constants
  - state enum (IDLE, RUN)
- Single module; FSM, timeout counter and decode inline. No sub-module.

## Test plan
- Reset: assert rst mid-cycle. All outputs are 0. Read ID → 16'hA1C0. Read STATUS → 0.
- ADD: A=0x12, B=0x34, OP=001, START. alu_start stays high until alu_done. RESULT → 0x0046, STATUS → 0x0002.
- MUL with a 3-cycle done: A=0xFF, B=0xFF, OP=100. A STATUS poll during RUN → 0x0001. RESULT → 0xFE01.
- Timeout: alu_done tied 0, OP=001, START. After 16 cycles alu_start=0 and STATUS → 0x0004. CLR_ERR → 0x0000.
- Busy protection: write A=0x55 while busy. A reads back its old value and err is set. A read of 0x0009 → 0x0000 and err stays set.
- no_op: OP=000, START. alu_start never rises. STATUS → 0x0002. RESULT unchanged.
